// File: rtl/push_feedback_driver_pkg.sv
// ============================================================================
// push_feedback_driver_pkg : shared rhythm package (state codes, timing defaults)
// Revision : 1.0
// ============================================================================
`default_nettype none

package push_feedback_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } fb_state_t;

  localparam int CNT_W  = 22;
  localparam int HALF_W = 15;

  localparam int DEF_HOLD_MAX  = 2_500_000;
  localparam int DEF_GAP_MAX   = 500_000;
  localparam int DEF_TONE_HALF = 25_000;

endpackage

`default_nettype wire

// File: rtl/push_feedback_driver_tone_divider.sv
// ============================================================================
// tone_divider : buzzer square-wave generator, held cleared while disabled
// Revision : 1.0
// ============================================================================
`default_nettype none

module tone_divider
  import push_feedback_driver_pkg::*;
#(
  parameter int TONE_HALF = DEF_TONE_HALF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_En,
  output logic o_Tone
);

  localparam logic [HALF_W-1:0] c_HalfLast = HALF_W'(TONE_HALF - 1);

  logic [HALF_W-1:0] r_Half;
  logic              r_Tone;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Half <= '0;
      r_Tone <= 1'b0;
    end else if (!i_En) begin
      r_Half <= '0;
      r_Tone <= 1'b0;
    end else if (r_Half == c_HalfLast) begin
      r_Half <= '0;
      r_Tone <= ~r_Tone;
    end else begin
      r_Half <= r_Half + 1'b1;
    end
  end

  assign o_Tone = r_Tone;

endmodule

`default_nettype wire

// File: rtl/push_feedback_driver.sv
// ============================================================================
// push_feedback_driver : LED/buzzer feedback sequencer with retrigger and gap
// Revision : 1.0
// ============================================================================
`default_nettype none

module push_feedback_driver
  import push_feedback_driver_pkg::*;
#(
  parameter int HOLD_MAX  = DEF_HOLD_MAX,
  parameter int GAP_MAX   = DEF_GAP_MAX,
  parameter int TONE_HALF = DEF_TONE_HALF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_fPush,
  input  logic i_Mute,
  output logic o_Led,
  output logic o_Buzz,
  output logic o_Busy,
  output logic o_fDone
);

  if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_MAX out of range for 22-bit counter");
  end
  if (GAP_MAX < 1 || GAP_MAX > (1 << CNT_W)) begin : g_bad_gap
    $error("GAP_MAX out of range for 22-bit counter");
  end
  if (TONE_HALF < 1 || TONE_HALF > (1 << HALF_W)) begin : g_bad_tone
    $error("TONE_HALF out of range for 15-bit counter");
  end

  localparam logic [CNT_W-1:0] c_HoldLast = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] c_GapLast  = CNT_W'(GAP_MAX - 1);

  fb_state_t        r_State;
  logic [CNT_W-1:0] r_Cnt;
  logic             r_Pend;
  logic             w_On;
  logic             w_Tone;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State <= S_IDLE;
      r_Cnt   <= '0;
      r_Pend  <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          r_Cnt  <= '0;
          r_Pend <= 1'b0;
          if (i_fPush) r_State <= S_ON;
        end
        S_ON: begin
          // A push on the terminal cycle still wins: it retriggers instead of ending.
          if (i_fPush) begin
            r_Cnt <= '0;
          end else if (r_Cnt == c_HoldLast) begin
            r_Cnt   <= '0;
            r_State <= S_GAP;
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_Cnt == c_GapLast) begin
            r_Cnt   <= '0;
            r_Pend  <= 1'b0;
            r_State <= (r_Pend || i_fPush) ? S_ON : S_IDLE;
          end else begin
            r_Cnt <= r_Cnt + 1'b1;
            if (i_fPush) r_Pend <= 1'b1;
          end
        end
        default: begin
          r_State <= S_IDLE;
          r_Cnt   <= '0;
          r_Pend  <= 1'b0;
        end
      endcase
    end
  end

  assign w_On = (r_State == S_ON);

  tone_divider #(
    .TONE_HALF (TONE_HALF)
  ) u_tone (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_En   (w_On),
    .o_Tone (w_Tone)
  );

  assign o_Led   = w_On;
  assign o_Buzz  = w_Tone & w_On & ~i_Mute;
  assign o_Busy  = (r_State != S_IDLE);
  assign o_fDone = (r_State == S_GAP) && (r_Cnt == c_GapLast) && !r_Pend && !i_fPush;

endmodule

`default_nettype wire

// File: tb/tb_push_feedback_driver.sv
// ============================================================================
// tb_push_feedback_driver : directed cycle-by-cycle checks, HOLD=8 GAP=4 HALF=2
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_push_feedback_driver;

  logic i_Clk   = 1'b0;
  logic i_Rst   = 1'b0;
  logic i_fPush = 1'b0;
  logic i_Mute  = 1'b0;
  logic o_Led, o_Buzz, o_Busy, o_fDone;

  int n_checks = 0;
  int n_fail   = 0;

  push_feedback_driver #(
    .HOLD_MAX  (8),
    .GAP_MAX   (4),
    .TONE_HALF (2)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_fPush (i_fPush),
    .i_Mute  (i_Mute),
    .o_Led   (o_Led),
    .o_Buzz  (o_Buzz),
    .o_Busy  (o_Busy),
    .o_fDone (o_fDone)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {led,buzz,busy,done}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Cycle c: push driven just after posedge c, outputs sampled at the following negedge.
  // Expected on-windows [s1,e1] and [s2,e2] (s2=0: none), o_fDone cycle dn.
  task automatic run(input string name, input int len, input int p0, input int p1,
                     input logic mute, input int s1, input int e1,
                     input int s2, input int e2, input int dn);
    logic led, buzz, busy, done;
    int   seg;
    for (int c = 0; c < len; c++) begin
      @(posedge i_Clk);
      #1;
      i_fPush = (c == p0) || (c == p1);
      i_Mute  = mute;
      @(negedge i_Clk);
      led  = (c >= s1 && c <= e1) || (s2 > 0 && c >= s2 && c <= e2);
      seg  = (s2 > 0 && c >= s2) ? s2 : s1;
      buzz = led && !mute && ((((c - seg) / 2) % 2) == 1);
      busy = (c >= 1) && (c <= dn);
      done = (c == dn);
      check($sformatf("%s_c%0d", name, c), {o_Led, o_Buzz, o_Busy, o_fDone},
            {led, buzz, busy, done});
    end
    i_fPush = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge i_Clk);
    check("reset_hold", {o_Led, o_Buzz, o_Busy, o_fDone}, 4'b0000);
    i_Rst = 1'b1;

    run("single",    16, 0, -1, 1'b0, 1, 8,  0,  0,  12);
    run("retrig5",   20, 0, 5,  1'b0, 1, 13, 0,  0,  17);
    run("gap_push",  28, 0, 10, 1'b0, 1, 8,  13, 20, 24);
    run("mute",      16, 0, -1, 1'b1, 1, 8,  0,  0,  12);
    run("term_push", 24, 0, 8,  1'b0, 1, 16, 0,  0,  20);

    // Reset in the middle of the on-time.
    run("pre_rst", 4, 0, -1, 1'b0, 1, 8, 0, 0, 99);
    #1 i_Rst = 1'b0;
    #1 check("rst_async", {o_Led, o_Buzz, o_Busy, o_fDone}, 4'b0000);
    @(posedge i_Clk);
    #1 i_fPush = 1'b1;
    @(negedge i_Clk);
    check("rst_push_ignored", {o_Led, o_Buzz, o_Busy, o_fDone}, 4'b0000);
    i_fPush = 1'b0;
    i_Rst   = 1'b1;
    run("post_rst", 16, 0, -1, 1'b0, 1, 8, 0, 0, 12);

    // Reset during the gap with a retrigger pending: pending must be dropped.
    run("gap_rst_pre", 12, 0, 10, 1'b0, 1, 8, 0, 0, 99);
    #1 i_Rst = 1'b0;
    #2 i_Rst = 1'b1;
    run("gap_rst_post", 14, -1, -1, 1'b0, 1, 0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
